stalling_mem_responder: RTL
===========================

Name: stalling_mem_responder

Overview:
- Responder (memory side) of the memory-stage request interface (Addr/DataIn/Rd/Wr in; DataOut/Done/Stall/err out).
- Models a multi-cycle, word-aligned 16-bit data memory with fixed access latency and a Stall/Done handshake.
- Sits behind the memory stage in place of the single-cycle aligned memory.
- Exercises pipeline stall logic before a real cache is integrated.

Parameters:
- ADDR_W, 8: word-index bits; the array holds 2^ADDR_W 16-bit words; byte address bits [ADDR_W:1] select the word.
- LATENCY, 4: cycles from request acceptance to the Done cycle; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Addr  in  16  byte address; bit 0 must be 0.
- DataIn  in  16  write data.
- Rd  in  1  read request.
- Wr  in  1  write request.
- DataOut  out  16  read data, registered.
- Done  out  1  one-cycle completion pulse, registered.
- Stall  out  1  busy indication; the initiator must hold off new requests while it is high.
- err  out  1  error flag, valid only in the Done cycle, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: DataOut=0, Done=0, err=0, state=IDLE, cnt=0. Stall=0 after reset.
- Array contents: not cleared by reset and retain their values.
- States:
  - IDLE: Stall=0.
  - BUSY: Stall=1 while cnt<LATENCY-1.
  - DONE: Stall=0, Done=1.
- Acceptance: a request is accepted on a rising edge where state is IDLE or DONE and (Rd|Wr)=1. Addr, DataIn, Rd and Wr are captured at that edge.
- Timing (call the accepting edge 0):
  - Cycles 1..LATENCY-1: state BUSY, Stall=1.
  - Cycle LATENCY: state DONE, Done=1.
  - LATENCY=1: the next state is DONE directly, and Stall is never asserted.
- Array access: occurs at edge LATENCY-1→LATENCY, which is the edge entering DONE.
  - Read: DataOut <= mem[addr_q[ADDR_W:1]].
  - Write: mem[...] <= data_q. DataOut is unchanged.
- DataOut hold: DataOut holds its last read value until the next successful read completes.
- Leaving DONE:
  - If a new request is present, it is accepted at that edge, giving back-to-back operation with no idle bubble.
  - Otherwise the next state is IDLE.
- Ignored inputs: requests presented while BUSY are ignored, with no capture and no error.
- Error cases: Rd&Wr both 1, or Addr[0]=1 with Rd|Wr.
  - The request is still accepted and runs the full latency.
  - The array is not modified and DataOut is unchanged.
  - err=1 together with Done in cycle LATENCY.
- Outside the Done cycle: err=0.
- Address wrap: Addr bits above ADDR_W are ignored, so addresses wrap modulo 2^(ADDR_W+1) bytes.
- Reset mid-operation: the next state is IDLE, no Done is produced, and a pending write is discarded without touching the array.
- Counter: a 4-bit cnt, cleared on acceptance and incremented in BUSY. Its width comfortably covers LATENCY≤15.

Test Plan:
- Write then read, LATENCY=4:
  - Stimulus: Wr, Addr=0x0010, DataIn=0xBEEF at edge 0; then Rd, Addr=0x0010.
  - Response: Stall=1 in cycles 1–3 and Done=1 in cycle 4 for each transaction. On the read Done, DataOut=0xBEEF and err=0.
- Back-to-back:
  - Stimulus: a read of 0x0020 presented during the Done cycle of a prior write.
  - Response: it is accepted at that edge, its Done follows 4 cycles later, and no IDLE cycle occurs between the transactions.
- Misaligned:
  - Stimulus: Wr, Addr=0x0011, DataIn=0x1234.
  - Response: Done with err=1 in cycle 4. A later read of 0x0010 returns the prior value, not 0x1234.
- Illegal Rd&Wr:
  - Stimulus: Rd=Wr=1.
  - Response: err=1 with Done, the array is unchanged, and DataOut is unchanged.
- Reset mid-write:
  - Stimulus: Wr 0x0030=0xAAAA, then rst=1 in cycle 2.
  - Response: no Done, Stall=0 the cycle after reset, and a read of 0x0030 returns the old contents.
- LATENCY=1 and wrap:
  - Stimulus: with LATENCY=1, write 0x5A5A to Addr=0x0200 (ADDR_W=8), then read Addr=0x0000.
  - Response: Done the cycle after each request, Stall is never 1, and the read returns 0x5A5A.

Source files
------------

// File: rtl/stalling_mem_responder.sv
// Word-aligned 16-bit data memory with a fixed access latency and a Stall/Done handshake.
// It stands in for the single-cycle memory so that the pipeline's stall logic can be exercised.
module stalling_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] LAST_BUSY_CNT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [3:0] STALL_LIMIT   = 4'(LATENCY - 1);
    localparam bit         DIRECT        = (LATENCY == 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [15:0]       r_data;
    logic              r_rd;
    logic              r_wr;
    logic              r_bad;
    logic [15:0]       r_dout;
    logic              r_done;
    logic              r_err;
    logic [15:0]       r_mem [0:(2**ADDR_W)-1];

    logic              w_req;
    logic              w_bad_live;
    logic              w_accept;
    logic              w_finish;
    logic              w_stall;
    logic              w_op_rd;
    logic              w_op_wr;
    logic              w_op_bad;
    logic [ADDR_W-1:0] w_op_idx;
    logic [15:0]       w_op_data;
    logic              w_unused_addr_hi;

    assign w_req            = Rd | Wr;
    assign w_bad_live       = (Rd & Wr) | (Addr[0] & w_req);
    assign w_unused_addr_hi = ^Addr[15:ADDR_W+1];

    // With a one-cycle latency the access happens on the accepting edge itself,
    // so the operands come straight from the ports instead of the capture registers.
    assign w_op_rd   = DIRECT ? Rd                : r_rd;
    assign w_op_wr   = DIRECT ? Wr                : r_wr;
    assign w_op_bad  = DIRECT ? w_bad_live        : r_bad;
    assign w_op_idx  = DIRECT ? Addr[ADDR_W:1]    : r_idx;
    assign w_op_data = DIRECT ? DataIn            : r_data;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_finish     = DIRECT;
                    w_next_state = DIRECT ? DONE : BUSY;
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                w_stall = (r_cnt < STALL_LIMIT);
                if (r_cnt == LAST_BUSY_CNT) begin
                    w_next_state = DONE;
                    w_finish     = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_dout <= 16'd0;
        end else begin
            if (w_accept) begin
                r_cnt <= 4'd0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 4'd1;
            end
            r_done <= w_finish;
            r_err  <= w_finish & w_op_bad;
            if (w_finish && w_op_rd && !w_op_bad) begin
                r_dout <= r_mem[w_op_idx];
            end
        end
    end

    // NOTE: the request capture registers and the array carry no reset; they are only
    // consumed after a capture or a write, and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx  <= Addr[ADDR_W:1];
            r_data <= DataIn;
            r_rd   <= Rd;
            r_wr   <= Wr;
            r_bad  <= w_bad_live;
        end
    end

    // A reset landing on the completing edge discards the pending write.
    always_ff @(posedge clk) begin
        if (!rst && w_finish && w_op_wr && !w_op_bad) begin
            r_mem[w_op_idx] <= w_op_data;
        end
    end

    assign DataOut = r_dout;
    assign Done    = r_done;
    assign err     = r_err;
    assign Stall   = w_stall;

endmodule
